// File: rtl/tpm_tis_regs.sv
// TIS locality-0 register file with command/response byte buffer.
// Host side is driven by decoded LPC strobes; the backend shares the buffer during EXECUTION.
module tpm_tis_regs #(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] DID_VID = 32'h001A_15D1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                addr,
  input  logic [7:0]                 wrData,
  input  logic                       didWrite,
  input  logic                       didRead,
  output logic [7:0]                 rdData,
  output logic                       exec_go,
  output logic [$clog2(DEPTH):0]     cmd_len,
  input  logic [$clog2(DEPTH)-1:0]   buf_addr,
  input  logic                       buf_we,
  input  logic [7:0]                 buf_wdata,
  output logic [7:0]                 buf_rdata,
  input  logic                       exec_done,
  input  logic [$clog2(DEPTH):0]     rsp_len
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_RECEPTION, S_EXECUTION, S_COMPLETION
  } state_e;

  state_e          state_q, state_d;
  logic            active_q, active_d;
  logic [AW:0]     wcount_q, wcount_d;
  logic [AW:0]     rcount_q, rcount_d;
  logic [31:0]     cmdRaw_q, cmdRaw_d;
  logic [AW:0]     rspCnt_q, rspCnt_d;
  logic            execGo_q, execGo_d;
  logic [AW:0]     cmdLen_q, cmdLen_d;

  logic [7:0]      mem [DEPTH];
  logic            memWe;
  logic [AW-1:0]   memWAddr;
  logic [7:0]      memWData;

  logic            inLoc;
  logic [11:0]     off;
  logic            isAccess, isSts, isFifo;
  logic [AW:0]     cmdSize;
  logic            expectBit, dataAvail;
  logic [AW:0]     burst;
  logic [15:0]     burst16;
  logic [7:0]      hostRd;

  assign inLoc    = (addr[15:12] == 4'h0);
  assign off      = addr[11:0];
  assign isAccess = inLoc && (off == 12'h000);
  assign isSts    = inLoc && (off == 12'h018);
  assign isFifo   = inLoc && (off == 12'h024);

  // Command length field is big-endian bytes 2..5, clipped to what the buffer can hold.
  assign cmdSize   = (cmdRaw_q > 32'(DEPTH)) ? DEPTH_L : cmdRaw_q[AW:0];
  assign expectBit = (state_q == S_RECEPTION) &&
                     ((wcount_q < (AW+1)'(6)) || (wcount_q < cmdSize));
  assign dataAvail = (state_q == S_COMPLETION) && (rcount_q < rspCnt_q);
  assign hostRd    = mem[rcount_q[AW-1:0]];
  assign burst16   = 16'(burst);

  always_comb begin
    burst = '0;
    case (state_q)
      S_READY, S_RECEPTION: burst = DEPTH_L - wcount_q;
      S_COMPLETION:         burst = rspCnt_q - rcount_q;
      default:              burst = '0;
    endcase
  end

  always_comb begin
    rdData = 8'hFF;
    if (inLoc) begin
      case (off)
        12'h000: rdData = {2'b10, active_q, 5'b00000};
        12'h018: if (active_q) rdData = {1'b1, state_q == S_READY, 1'b0, dataAvail, expectBit, 3'b000};
        12'h019: if (active_q) rdData = burst16[7:0];
        12'h01A: if (active_q) rdData = burst16[15:8];
        12'h01B: if (active_q) rdData = 8'h00;
        12'h024: if (active_q && dataAvail) rdData = hostRd;
        12'hF00: rdData = DID_VID[7:0];
        12'hF01: rdData = DID_VID[15:8];
        12'hF02: rdData = DID_VID[23:16];
        12'hF03: rdData = DID_VID[31:24];
        default: rdData = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    wcount_d = wcount_q;
    rcount_d = rcount_q;
    cmdRaw_d = cmdRaw_q;
    rspCnt_d = rspCnt_q;
    execGo_d = 1'b0;
    cmdLen_d = cmdLen_q;
    memWe    = 1'b0;
    memWAddr = buf_addr;
    memWData = buf_wdata;

    if (state_q == S_EXECUTION) begin
      memWe = buf_we;
      if (exec_done) begin
        state_d  = S_COMPLETION;
        rspCnt_d = (rsp_len > DEPTH_L) ? DEPTH_L : rsp_len;
        rcount_d = '0;
      end
    end

    // A host write in the same cycle as a read wins; the read's side effect is dropped.
    if (didWrite) begin
      if (isAccess) begin
        if (wrData[5])      active_d = 1'b0;
        else if (wrData[1]) active_d = 1'b1;
      end
      if (active_q && isSts) begin
        if (wrData[6]) begin
          if (state_q != S_EXECUTION) begin
            state_d  = S_READY;
            wcount_d = '0;
            rcount_d = '0;
            cmdRaw_d = '0;
            cmdLen_d = '0;
          end
        end else if (wrData[5] && state_q == S_RECEPTION && !expectBit) begin
          state_d  = S_EXECUTION;
          execGo_d = 1'b1;
          cmdLen_d = wcount_q;
        end
      end
      if (active_q && isFifo && (state_q == S_READY || state_q == S_RECEPTION) &&
          wcount_q < DEPTH_L) begin
        memWe    = 1'b1;
        memWAddr = wcount_q[AW-1:0];
        memWData = wrData;
        wcount_d = wcount_q + 1'b1;
        state_d  = S_RECEPTION;
        if (wcount_q >= (AW+1)'(2) && wcount_q <= (AW+1)'(5))
          cmdRaw_d = {cmdRaw_q[23:0], wrData};
      end
    end else if (didRead && active_q && isFifo && dataAvail) begin
      rcount_d = rcount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      wcount_q <= '0;
      rcount_q <= '0;
      cmdRaw_q <= '0;
      rspCnt_q <= '0;
      execGo_q <= 1'b0;
      cmdLen_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      wcount_q <= wcount_d;
      rcount_q <= rcount_d;
      cmdRaw_q <= cmdRaw_d;
      rspCnt_q <= rspCnt_d;
      execGo_q <= execGo_d;
      cmdLen_q <= cmdLen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= memWData;
  end

  assign exec_go   = execGo_q;
  assign cmd_len   = cmdLen_q;
  assign buf_rdata = mem[buf_addr];

endmodule

// File: tb/tb_tpm_tis_regs.sv
// Directed self-checking bench for tpm_tis_regs with DEPTH=64.
// Each scenario task drives the host/backend strobes and checks its own expected values.
module tb_tpm_tis_regs;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   addr = 16'h0;
  logic [7:0]    wrData = 8'h0;
  logic          didWrite = 1'b0;
  logic          didRead = 1'b0;
  logic [7:0]    rdData;
  logic          exec_go;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] buf_addr = '0;
  logic          buf_we = 1'b0;
  logic [7:0]    buf_wdata = 8'h0;
  logic [7:0]    buf_rdata;
  logic          exec_done = 1'b0;
  logic [AW:0]   rsp_len = '0;

  int total = 0;
  int bad = 0;
  int goCount = 0;

  tpm_tis_regs #(.DEPTH(DEPTH), .DID_VID(32'h001A_15D1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wrData(wrData),
    .didWrite(didWrite), .didRead(didRead), .rdData(rdData),
    .exec_go(exec_go), .cmd_len(cmd_len), .buf_addr(buf_addr),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .exec_done(exec_done), .rsp_len(rsp_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (exec_go) goCount++;

  task automatic hostWrite(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wrData = d; didWrite = 1'b1;
    @(negedge clk);
    didWrite = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a;
    #1 v = rdData;
  endtask

  task automatic hostRead(input logic [15:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a;
    #1 v = rdData;
    didRead = 1'b1;
    @(negedge clk);
    didRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    peek(16'h0000, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL reset_access got=%h exp=80", v); end
    peek(16'h0018, v); total++;
    if (v !== 8'hFF) begin bad++; $display("[TB] FAIL inactive_sts got=%h exp=FF", v); end
    peek(16'h0F00, v); total++;
    if (v !== 8'hD1) begin bad++; $display("[TB] FAIL didvid0 got=%h exp=D1", v); end
    peek(16'h0F02, v); total++;
    if (v !== 8'h1A) begin bad++; $display("[TB] FAIL didvid2 got=%h exp=1A", v); end
    total++;
    if (cmd_len !== '0 || exec_go !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_outputs cmd_len=%0d exec_go=%b exp=0/0", cmd_len, exec_go);
    end
    hostWrite(16'h0000, 8'h02);
    peek(16'h0000, v); total++;
    if (v !== 8'hA0) begin bad++; $display("[TB] FAIL active_access got=%h exp=A0", v); end
    peek(16'h0018, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL idle_sts got=%h exp=80", v); end
    peek(16'h1018, v); total++;
    if (v !== 8'hFF) begin bad++; $display("[TB] FAIL other_locality got=%h exp=FF", v); end
  endtask

  task automatic test_ready();
    logic [7:0] v;
    hostWrite(16'h0018, 8'h40);
    peek(16'h0018, v); total++;
    if (v !== 8'hC0) begin bad++; $display("[TB] FAIL ready_sts got=%h exp=C0", v); end
    peek(16'h0019, v); total++;
    if (v !== 8'h40) begin bad++; $display("[TB] FAIL ready_burst_lo got=%h exp=40", v); end
    peek(16'h001A, v); total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL ready_burst_hi got=%h exp=00", v); end
  endtask

  task automatic test_command();
    logic [7:0] v;
    logic [7:0] cmd [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};
    for (int i = 0; i < 10; i++) begin
      hostWrite(16'h0024, cmd[i]);
      if (i == 0) begin
        peek(16'h0018, v); total++;
        if (v !== 8'h88) begin bad++; $display("[TB] FAIL first_byte_sts got=%h exp=88", v); end
      end
      if (i == 5) begin
        // tpmGo while still expecting bytes must be ignored.
        hostWrite(16'h0018, 8'h20);
        repeat (2) @(negedge clk);
        total++;
        if (goCount !== 0) begin bad++; $display("[TB] FAIL early_go got=%0d exp=0", goCount); end
      end
    end
    peek(16'h0018, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL full_cmd_sts got=%h exp=80", v); end
    peek(16'h0019, v); total++;
    if (v !== 8'd54) begin bad++; $display("[TB] FAIL full_cmd_burst got=%0d exp=54", v); end
    hostWrite(16'h0018, 8'h20);
    repeat (2) @(negedge clk);
    total++;
    if (goCount !== 1) begin bad++; $display("[TB] FAIL exec_go_count got=%0d exp=1", goCount); end
    total++;
    if (cmd_len !== 7'd10) begin bad++; $display("[TB] FAIL cmd_len got=%0d exp=10", cmd_len); end
    buf_addr = 6'd9;
    #1; total++;
    if (buf_rdata !== 8'h44) begin bad++; $display("[TB] FAIL backend_rd9 got=%h exp=44", buf_rdata); end
    peek(16'h0019, v); total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL exec_burst got=%h exp=00", v); end
  endtask

  task automatic test_response();
    logic [7:0] v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      buf_addr = 6'(i); buf_wdata = 8'hA0 + 8'(i); buf_we = 1'b1;
    end
    @(negedge clk);
    buf_we = 1'b0; exec_done = 1'b1; rsp_len = 7'd10;
    @(negedge clk);
    exec_done = 1'b0;
    peek(16'h0018, v); total++;
    if (v !== 8'h90) begin bad++; $display("[TB] FAIL compl_sts got=%h exp=90", v); end
    peek(16'h0019, v); total++;
    if (v !== 8'd10) begin bad++; $display("[TB] FAIL compl_burst got=%0d exp=10", v); end
    for (int i = 0; i < 10; i++) begin
      hostRead(16'h0024, v); total++;
      if (v !== 8'hA0 + 8'(i)) begin
        bad++; $display("[TB] FAIL rsp_byte%0d got=%h exp=%h", i, v, 8'hA0 + 8'(i));
      end
    end
    peek(16'h0018, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL drained_sts got=%h exp=80", v); end
    hostRead(16'h0024, v); total++;
    if (v !== 8'hFF) begin bad++; $display("[TB] FAIL empty_read got=%h exp=FF", v); end
    @(negedge clk);
    buf_addr = 6'd0; buf_wdata = 8'h55; buf_we = 1'b1;
    @(negedge clk);
    buf_we = 1'b0;
    #1; total++;
    if (buf_rdata !== 8'hA0) begin bad++; $display("[TB] FAIL we_outside_exec got=%h exp=A0", buf_rdata); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    hostWrite(16'h0018, 8'h40);
    for (int i = 0; i < 65; i++) hostWrite(16'h0024, 8'(i));
    peek(16'h0019, v); total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL overflow_burst got=%h exp=00", v); end
    peek(16'h0018, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL overflow_sts got=%h exp=80", v); end
    hostWrite(16'h0018, 8'h20);
    repeat (2) @(negedge clk);
    total++;
    if (cmd_len !== 7'd64) begin bad++; $display("[TB] FAIL overflow_cmd_len got=%0d exp=64", cmd_len); end
    total++;
    if (goCount !== 2) begin bad++; $display("[TB] FAIL overflow_go got=%0d exp=2", goCount); end
    buf_addr = 6'd63;
    #1; total++;
    if (buf_rdata !== 8'd63) begin bad++; $display("[TB] FAIL buf63 got=%h exp=3F", buf_rdata); end
    hostWrite(16'h0024, 8'h99);
    buf_addr = 6'd0;
    #1; total++;
    if (buf_rdata !== 8'h00) begin bad++; $display("[TB] FAIL exec_host_write got=%h exp=00", buf_rdata); end
    @(negedge clk);
    exec_done = 1'b1; rsp_len = 7'd100;
    @(negedge clk);
    exec_done = 1'b0;
    peek(16'h0019, v); total++;
    if (v !== 8'd64) begin bad++; $display("[TB] FAIL rsp_clip got=%0d exp=64", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    hostWrite(16'h0018, 8'h40);
    for (int i = 0; i < 3; i++) hostWrite(16'h0024, 8'h11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    peek(16'h0018, v); total++;
    if (v !== 8'hFF) begin bad++; $display("[TB] FAIL midrst_sts got=%h exp=FF", v); end
    peek(16'h0000, v); total++;
    if (v !== 8'h80) begin bad++; $display("[TB] FAIL midrst_access got=%h exp=80", v); end
    total++;
    if (goCount !== 2 || cmd_len !== '0) begin
      bad++; $display("[TB] FAIL midrst_go go=%0d cmd_len=%0d exp=2/0", goCount, cmd_len);
    end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_command();
    test_response();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
